// File: rtl/logic_unit_pipe.sv
`default_nettype none
// ============================================================================
//  Module   : logic_unit_pipe
//  Purpose  : Pipelined AND/OR/XOR/XNOR unit with valid/ready flow control
//             and an XOR-fold checksum accumulator over retired results.
//  Revision : 1.0  initial release
// ============================================================================
module logic_unit_pipe #(
   parameter int WIDTH  = 16,
   parameter int STAGES = 2
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid_i,
   output logic             in_ready_o,
   input  logic [1:0]       op_i,
   input  logic             acc_en_i,
   input  logic             acc_clr_i,
   input  logic [WIDTH-1:0] in1_i,
   input  logic [WIDTH-1:0] in2_i,
   output logic             out_valid_o,
   input  logic             out_ready_i,
   output logic [WIDTH-1:0] out_o,
   output logic             parity_o,
   output logic [WIDTH-1:0] acc_o
);

   localparam logic [1:0] OP_AND  = 2'b00;
   localparam logic [1:0] OP_OR   = 2'b01;
   localparam logic [1:0] OP_XOR  = 2'b10;
   localparam logic [1:0] OP_XNOR = 2'b11;

   logic [WIDTH-1:0]  result;
   logic              adv;
   logic              accept;
   logic              retire;
   logic [STAGES-1:0] vld_q;
   logic [STAGES-1:0] en_q;
   logic [WIDTH-1:0]  data_q [STAGES];
   logic [WIDTH-1:0]  acc_q;
   logic [WIDTH-1:0]  acc_d;

   always_comb begin
      result = '0;
      case (op_i)
         OP_AND:  result = in1_i & in2_i;
         OP_OR:   result = in1_i | in2_i;
         OP_XOR:  result = in1_i ^ in2_i;
         OP_XNOR: result = ~(in1_i ^ in2_i);
         default: result = '0;
      endcase
   end

   // Global stall: the whole pipe advances only when the output slot frees up.
   assign adv    = !vld_q[STAGES-1] || out_ready_i;
   assign accept = in_valid_i && adv;
   assign retire = vld_q[STAGES-1] && out_ready_i;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         vld_q <= '0;
         en_q  <= '0;
         for (int i = 0; i < STAGES; i++) begin
            data_q[i] <= '0;
         end
      end else if (adv) begin
         vld_q[0] <= accept;
         en_q[0]  <= accept && acc_en_i;
         if (accept) begin
            data_q[0] <= result;
         end
         for (int i = 1; i < STAGES; i++) begin
            vld_q[i]  <= vld_q[i-1];
            en_q[i]   <= en_q[i-1];
            data_q[i] <= data_q[i-1];
         end
      end
   end

   // Clear has priority, but a beat retiring in the same cycle still folds in.
   always_comb begin
      acc_d = acc_q;
      if (acc_clr_i) begin
         acc_d = (retire && en_q[STAGES-1]) ? data_q[STAGES-1] : '0;
      end else if (retire && en_q[STAGES-1]) begin
         acc_d = acc_q ^ data_q[STAGES-1];
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         acc_q <= '0;
      end else begin
         acc_q <= acc_d;
      end
   end

   assign in_ready_o  = adv;
   assign out_valid_o = vld_q[STAGES-1];
   assign out_o       = data_q[STAGES-1];
   assign parity_o    = ^data_q[STAGES-1];
   assign acc_o       = acc_q;

endmodule
`default_nettype wire

// File: tb/tb_logic_unit_pipe.sv
`default_nettype none
// ============================================================================
//  Module   : tb_logic_unit_pipe
//  Purpose  : Checks three logic_unit_pipe configurations against a beat-queue
//             reference model under directed and random traffic.
//  Revision : 1.0  initial release
// ============================================================================
module tb_logic_unit_pipe;

   localparam int C_W [3] = '{16, 8, 32};
   localparam int C_S [3] = '{2, 1, 4};

   logic        clk = 1'b0;
   logic        rst;
   logic        in_valid;
   logic [1:0]  op;
   logic        acc_en;
   logic        acc_clr;
   logic        out_ready;
   logic [31:0] a;
   logic [31:0] b;

   logic [15:0] out16, acc16;
   logic [7:0]  out8,  acc8;
   logic [31:0] out32, acc32;
   logic        rdy   [3];
   logic        ov    [3];
   logic        par   [3];
   logic [31:0] o_out [3];
   logic [31:0] o_acc [3];

   int total = 0;
   int bad   = 0;

   // Reference model: per-configuration list of in-flight beats, oldest first.
   // pos counts how many advancing edges a beat has seen since acceptance.
   logic [31:0] q_data [3][8];
   logic        q_en   [3][8];
   int          q_pos  [3][8];
   int          q_cnt  [3];
   logic [31:0] m_acc  [3];

   always #5 clk = ~clk;

   logic_unit_pipe #(.WIDTH(16), .STAGES(2)) u_dut16 (
      .clk(clk), .rst(rst), .in_valid_i(in_valid), .in_ready_o(rdy[0]),
      .op_i(op), .acc_en_i(acc_en), .acc_clr_i(acc_clr),
      .in1_i(a[15:0]), .in2_i(b[15:0]), .out_valid_o(ov[0]),
      .out_ready_i(out_ready), .out_o(out16), .parity_o(par[0]), .acc_o(acc16));

   logic_unit_pipe #(.WIDTH(8), .STAGES(1)) u_dut8 (
      .clk(clk), .rst(rst), .in_valid_i(in_valid), .in_ready_o(rdy[1]),
      .op_i(op), .acc_en_i(acc_en), .acc_clr_i(acc_clr),
      .in1_i(a[7:0]), .in2_i(b[7:0]), .out_valid_o(ov[1]),
      .out_ready_i(out_ready), .out_o(out8), .parity_o(par[1]), .acc_o(acc8));

   logic_unit_pipe #(.WIDTH(32), .STAGES(4)) u_dut32 (
      .clk(clk), .rst(rst), .in_valid_i(in_valid), .in_ready_o(rdy[2]),
      .op_i(op), .acc_en_i(acc_en), .acc_clr_i(acc_clr),
      .in1_i(a), .in2_i(b), .out_valid_o(ov[2]),
      .out_ready_i(out_ready), .out_o(out32), .parity_o(par[2]), .acc_o(acc32));

   assign o_out[0] = {16'h0, out16};
   assign o_out[1] = {24'h0, out8};
   assign o_out[2] = out32;
   assign o_acc[0] = {16'h0, acc16};
   assign o_acc[1] = {24'h0, acc8};
   assign o_acc[2] = acc32;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      if (obs !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
      end
   endtask

   function automatic logic [31:0] mask_of(input int w);
      return (w >= 32) ? 32'hFFFF_FFFF : ((32'd1 << w) - 32'd1);
   endfunction

   function automatic logic [31:0] ref_op(input logic [1:0] o, input logic [31:0] x,
                                          input logic [31:0] y);
      case (o)
         2'd0:    return x & y;
         2'd1:    return x | y;
         2'd2:    return x ^ y;
         default: return ~(x ^ y);
      endcase
   endfunction

   task automatic model_reset();
      for (int k = 0; k < 3; k++) begin
         q_cnt[k] = 0;
         m_acc[k] = '0;
      end
   endtask

   // Drive one cycle of inputs at the falling edge, compare, then advance the model.
   task automatic step(input logic iv, input logic [1:0] o, input logic [31:0] x,
                       input logic [31:0] y, input logic en, input logic clr,
                       input logic ordy);
      in_valid = iv; op = o; a = x; b = y; acc_en = en; acc_clr = clr; out_ready = ordy;
      #1;
      for (int k = 0; k < 3; k++) begin
         logic e_ov, adv, ret;
         e_ov = (q_cnt[k] > 0) && (q_pos[k][0] == C_S[k] - 1);
         adv  = !e_ov || ordy;
         ret  = e_ov && ordy;
         chk($sformatf("in_ready[%0d]", k), {31'h0, rdy[k]}, {31'h0, adv});
         chk($sformatf("out_valid[%0d]", k), {31'h0, ov[k]}, {31'h0, e_ov});
         if (e_ov) begin
            chk($sformatf("out[%0d]", k), o_out[k], q_data[k][0]);
            chk($sformatf("parity[%0d]", k), {31'h0, par[k]}, {31'h0, ^q_data[k][0]});
         end
         chk($sformatf("acc[%0d]", k), o_acc[k], m_acc[k]);
         if (clr && ret && q_en[k][0])  m_acc[k] = q_data[k][0];
         else if (clr)                  m_acc[k] = '0;
         else if (ret && q_en[k][0])    m_acc[k] = m_acc[k] ^ q_data[k][0];
         if (ret) begin
            for (int j = 1; j < q_cnt[k]; j++) begin
               q_data[k][j-1] = q_data[k][j];
               q_en[k][j-1]   = q_en[k][j];
               q_pos[k][j-1]  = q_pos[k][j];
            end
            q_cnt[k]--;
         end
         if (adv) begin
            for (int j = 0; j < q_cnt[k]; j++) q_pos[k][j]++;
            if (iv) begin
               q_data[k][q_cnt[k]] = ref_op(o, x, y) & mask_of(C_W[k]);
               q_en[k][q_cnt[k]]   = en;
               q_pos[k][q_cnt[k]]  = 0;
               q_cnt[k]++;
            end
         end
      end
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step(1'b0, 2'd0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b1);
   endtask

   initial begin
      rst = 1'b1; in_valid = 1'b0; op = 2'd0; acc_en = 1'b0; acc_clr = 1'b0;
      out_ready = 1'b1; a = '0; b = '0;
      model_reset();
      repeat (2) @(negedge clk);
      rst = 1'b0;
      #1;
      for (int k = 0; k < 3; k++) begin
         chk($sformatf("rst_ov[%0d]", k), {31'h0, ov[k]}, 32'h0);
         chk($sformatf("rst_out[%0d]", k), o_out[k], 32'h0);
         chk($sformatf("rst_par[%0d]", k), {31'h0, par[k]}, 32'h0);
         chk($sformatf("rst_acc[%0d]", k), o_acc[k], 32'h0);
         chk($sformatf("rst_rdy[%0d]", k), {31'h0, rdy[k]}, 32'h1);
      end
      @(negedge clk);

      // Single XOR beat and its latency on the 16-bit, 2-stage unit
      step(1'b1, 2'd2, 32'h0000_F0F0, 32'h0000_FF00, 1'b0, 1'b0, 1'b1);
      chk("t1_not_yet", {31'h0, ov[0]}, 32'h0);
      step(1'b0, 2'd0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b1);
      chk("t1_valid", {31'h0, ov[0]}, 32'h1);
      chk("t1_out", {16'h0, out16}, 32'h0000_0FF0);
      chk("t1_par", {31'h0, par[0]}, 32'h0);
      idle(4);

      // Back-to-back beats over all four ops
      step(1'b1, 2'd0, 32'hA5A5_F0F0, 32'h3C3C_FF00, 1'b0, 1'b0, 1'b1);
      chk("t2_rdy0", {31'h0, rdy[0]}, 32'h1);
      step(1'b1, 2'd1, 32'hA5A5_F0F0, 32'h3C3C_FF00, 1'b0, 1'b0, 1'b1);
      chk("t2_first", {16'h0, out16}, 32'h0000_F000);
      step(1'b1, 2'd3, 32'hA5A5_F0F0, 32'h3C3C_FF00, 1'b0, 1'b0, 1'b1);
      chk("t2_second", {16'h0, out16}, 32'h0000_FFF0);
      step(1'b1, 2'd2, 32'hA5A5_F0F0, 32'h3C3C_FF00, 1'b0, 1'b0, 1'b1);
      chk("t2_third", {16'h0, out16}, 32'h0000_F00F);
      idle(5);

      // Output stalled for 5 cycles while 3 beats are offered
      step(1'b1, 2'd0, 32'h1111_1111, 32'hFFFF_FFFF, 1'b0, 1'b0, 1'b0);
      step(1'b1, 2'd1, 32'h2222_2222, 32'h0000_0000, 1'b0, 1'b0, 1'b0);
      step(1'b1, 2'd2, 32'h3333_3333, 32'h0000_0000, 1'b0, 1'b0, 1'b0);
      step(1'b0, 2'd0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0);
      step(1'b0, 2'd0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0);
      idle(6);

      // Accumulator fold, non-folding beat, clear-with-retire, plain clear
      step(1'b1, 2'd2, 32'h0000_1234, 32'h0, 1'b1, 1'b0, 1'b1);
      step(1'b1, 2'd2, 32'h0000_00FF, 32'h0, 1'b1, 1'b0, 1'b1);
      step(1'b1, 2'd2, 32'h0000_5555, 32'h0, 1'b0, 1'b0, 1'b1);
      idle(5);
      chk("t4_acc", {16'h0, acc16}, 32'h0000_12CB);
      step(1'b1, 2'd2, 32'h0000_AAAA, 32'h0, 1'b1, 1'b0, 1'b1);
      step(1'b0, 2'd0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b1);
      step(1'b0, 2'd0, 32'h0, 32'h0, 1'b0, 1'b1, 1'b1);
      chk("t5_clr_fold", {16'h0, acc16}, 32'h0000_AAAA);
      step(1'b0, 2'd0, 32'h0, 32'h0, 1'b0, 1'b1, 1'b1);
      chk("t5_clr", {16'h0, acc16}, 32'h0);
      idle(5);

      // Reset with beats in flight and the output stalled
      step(1'b1, 2'd2, 32'h0000_00FF, 32'h0, 1'b1, 1'b0, 1'b1);
      step(1'b1, 2'd2, 32'h0000_0F0F, 32'h0, 1'b1, 1'b0, 1'b0);
      step(1'b1, 2'd1, 32'h0000_7777, 32'h0, 1'b1, 1'b0, 1'b0);
      rst = 1'b1;
      #1;
      for (int k = 0; k < 3; k++) begin
         chk($sformatf("t6_ov[%0d]", k), {31'h0, ov[k]}, 32'h0);
         chk($sformatf("t6_acc[%0d]", k), o_acc[k], 32'h0);
      end
      model_reset();
      @(negedge clk);
      rst = 1'b0;
      step(1'b1, 2'd0, 32'h0000_FFFF, 32'h0000_1234, 1'b1, 1'b0, 1'b1);
      chk("t6_lat0", {31'h0, ov[0]}, 32'h0);
      step(1'b0, 2'd0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b1);
      chk("t6_lat1", {31'h0, ov[0]}, 32'h1);
      chk("t6_out", {16'h0, out16}, 32'h0000_1234);
      idle(5);

      // Random traffic
      for (int i = 0; i < 600; i++) begin
         step(1'($urandom_range(0, 3) != 0), 2'($urandom), $urandom, $urandom,
              1'($urandom), 1'($urandom_range(0, 19) == 0),
              1'($urandom_range(0, 3) != 0));
      end
      idle(6);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
`default_nettype wire
